// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if
// Handshake and operand/result bundle between the control unit (master)
// and the bit-serial ALU sequencer (slave).
//   start       : request pulse from the control unit
//   a, b        : WIDTH-bit operands
//   arit, s, sub: operation select (adder path, logic function, subtract)
//   busy, done  : sequencer status, done is a one-cycle pulse
//   result      : WIDTH-bit assembled result
//   c_out, zero : final carry and zero flag
//   ovf         : signed overflow flag, present only with ALU_SERIAL_OVF_EN
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             arit;
  logic [1:0]       s;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             zero;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, arit, s, sub,
    input  busy, done, result, c_out, zero, ovf
  );

  modport slave (
    input  start, a, b, arit, s, sub,
    output busy, done, result, c_out, zero, ovf
  );
`else
  modport master (
    output start, a, b, arit, s, sub,
    input  busy, done, result, c_out, zero
  );

  modport slave (
    input  start, a, b, arit, s, sub,
    output busy, done, result, c_out, zero
  );
`endif

endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial sequencer around a single one-bit ALU cell (cal). Operands are
// fed LSB first, one bit per clock, with the carry kept in a flip-flop and
// the result assembled in a shift register entering at the MSB.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : alu_serial_ctrl_if.slave (start/operands in, status/result out)
// Optional feature: define ALU_SERIAL_OVF_EN to add the signed overflow
// flag bus.ovf. Without it there is no ovf logic at all.

// One-bit ALU cell: logic cell and full adder, selected by arit.
// s: 00 AND, 01 OR, 10 XOR, 11 NOT A.
module cal (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       arit,
  input  logic [1:0] s,
  output logic       out,
  output logic       cout
);

  logic logic_bit;
  logic sum_bit;

  always_comb begin
    logic_bit = 1'b0;
    case (s)
      2'b00:   logic_bit = a & b;
      2'b01:   logic_bit = a | b;
      2'b10:   logic_bit = a ^ b;
      default: logic_bit = ~a;
    endcase
    sum_bit = a ^ b ^ cin;
    cout    = (a & b) | (a & cin) | (b & cin);
    out     = arit ? sum_bit : logic_bit;
  end

endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_serial_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             arit_q;
  logic [1:0]       s_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             zero_q;
  logic             accept;
  logic             last_bit;
  logic             cal_out;
  logic             cal_cout;
  logic [WIDTH-1:0] result_shifted;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  // A start is honoured whenever no operation is running, so DONE can
  // chain directly into the next RUN.
  assign accept         = bus.start && (state != RUN);
  assign last_bit       = (count == CNT_W'(WIDTH - 1));
  assign result_shifted = {cal_out, result_q[WIDTH-1:1]};

  cal u_cal (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .arit (arit_q),
    .s    (s_q),
    .out  (cal_out),
    .cout (cal_cout)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Datapath: B is pre-inverted and carry preset to 1 for subtraction so
  // the cell only ever adds. Flags are loaded on the final RUN edge so they
  // are valid in DONE and hold through the next RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      arit_q   <= 1'b0;
      s_q      <= 2'b00;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      count   <= '0;
      a_sr    <= bus.a;
      b_sr    <= bus.b ^ {WIDTH{bus.arit & bus.sub}};
      arit_q  <= bus.arit;
      s_q     <= bus.s;
      carry_q <= bus.arit & bus.sub;
    end else if (state == RUN) begin
      count    <= count + 1'b1;
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      carry_q  <= arit_q & cal_cout;
      result_q <= result_shifted;
      if (last_bit) begin
        c_out_q <= arit_q & cal_cout;
        zero_q  <= (result_shifted == '0);
`ifdef ALU_SERIAL_OVF_EN
        // carry_q is the carry into the MSB on this last edge
        ovf_q   <= arit_q & (carry_q ^ cal_cout);
`endif
      end
    end
  end

  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
  assign bus.zero   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl
// Directed testbench for alu_serial_ctrl with WIDTH=4. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// Define ALU_SERIAL_OVF_EN to also cover the ovf flag.
module tb_alu_serial_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_serial_ctrl_if #(.WIDTH(4)) bus ();

  alu_serial_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from IDLE/DONE and wait (bounded) for done.
  // Leaves the bench at the negedge inside the DONE cycle.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic t_arit, input logic [1:0] ts,
                       input logic t_sub, output int busy_cnt,
                       output bit got_done);
    @(negedge clk);
    bus.a = ta; bus.b = tb_v; bus.arit = t_arit; bus.s = ts; bus.sub = t_sub;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (bus.done) got_done = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        @(negedge clk);
      end
    end
    if (!got_done) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout got done=0 want done=1");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus.arit = 1'b0; bus.s = 2'b00; bus.sub = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 4'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_out got %b want 0", bus.c_out); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero got %b want 1", bus.zero); end
`ifdef ALU_SERIAL_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    int  bc;
    bit  ok;
    do_op(4'd5, 4'd3, 1'b1, 2'b00, 1'b0, bc, ok);
    checks++; if (bc !== 4) begin errors++; $display("[TB] FAIL add_busy_cycles got %0d want 4", bc); end
    checks++; if (bus.result !== 4'h8) begin errors++; $display("[TB] FAIL add_5_3_result got %h want 8", bus.result); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("[TB] FAIL add_5_3_c_out got %b want 0", bus.c_out); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL add_5_3_zero got %b want 0", bus.zero); end
`ifdef ALU_SERIAL_OVF_EN
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("[TB] FAIL add_5_3_ovf got %b want 1", bus.ovf); end
`endif
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL add_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.result !== 4'h8) begin errors++; $display("[TB] FAIL add_result_hold got %h want 8", bus.result); end

    do_op(4'd9, 4'd9, 1'b1, 2'b00, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'h2) begin errors++; $display("[TB] FAIL add_9_9_result got %h want 2", bus.result); end
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("[TB] FAIL add_9_9_c_out got %b want 1", bus.c_out); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL add_9_9_zero got %b want 0", bus.zero); end
`ifdef ALU_SERIAL_OVF_EN
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("[TB] FAIL add_9_9_ovf got %b want 1", bus.ovf); end
`endif
  endtask

  task automatic test_sub();
    int  bc;
    bit  ok;
    do_op(4'd5, 4'd3, 1'b1, 2'b00, 1'b1, bc, ok);
    checks++; if (bus.result !== 4'h2) begin errors++; $display("[TB] FAIL sub_5_3_result got %h want 2", bus.result); end
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("[TB] FAIL sub_5_3_c_out got %b want 1", bus.c_out); end
`ifdef ALU_SERIAL_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL sub_5_3_ovf got %b want 0", bus.ovf); end
`endif
    do_op(4'd3, 4'd5, 1'b1, 2'b00, 1'b1, bc, ok);
    checks++; if (bus.result !== 4'hE) begin errors++; $display("[TB] FAIL sub_3_5_result got %h want e", bus.result); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("[TB] FAIL sub_3_5_c_out got %b want 0", bus.c_out); end
  endtask

  task automatic test_logic();
    int  bc;
    bit  ok;
    // sub=1 must be ignored on the logic path
    do_op(4'hA, 4'h6, 1'b0, 2'b10, 1'b1, bc, ok);
    checks++; if (bus.result !== 4'hC) begin errors++; $display("[TB] FAIL xor_result got %h want c", bus.result); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("[TB] FAIL xor_c_out got %b want 0", bus.c_out); end
    do_op(4'hA, 4'h6, 1'b0, 2'b00, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'h2) begin errors++; $display("[TB] FAIL and_result got %h want 2", bus.result); end
    do_op(4'hA, 4'h6, 1'b0, 2'b01, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'hE) begin errors++; $display("[TB] FAIL or_result got %h want e", bus.result); end
    do_op(4'hA, 4'h6, 1'b0, 2'b11, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'h5) begin errors++; $display("[TB] FAIL nota_result got %h want 5", bus.result); end
    do_op(4'hA, 4'hA, 1'b0, 2'b10, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'h0) begin errors++; $display("[TB] FAIL xor_zero_result got %h want 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL xor_zero_flag got %b want 1", bus.zero); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    @(negedge clk);
    bus.a = 4'd1; bus.b = 4'd1; bus.arit = 1'b1; bus.s = 2'b00; bus.sub = 1'b0;
    bus.start = 1'b1;
    // accepted at edges 0, 5, 10 -> done seen at negedges 5, 10, 15
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== ((i % 5) == 0)) begin
        errors++; $display("[TB] FAIL b2b_done_%0d got %b want %b", i, bus.done, ((i % 5) == 0));
      end
      if ((i % 5) == 0) begin
        checks++;
        if (bus.result !== 4'h2) begin errors++; $display("[TB] FAIL b2b_result_%0d got %h want 2", i, bus.result); end
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    bit got_done;
    @(negedge clk);
    bus.a = 4'd5; bus.b = 4'd3; bus.arit = 1'b1; bus.s = 2'b00; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 4'd7; bus.b = 4'd7; bus.sub = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (bus.done) got_done = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!got_done) begin errors++; $display("[TB] FAIL ignore_done_timeout got 0 want 1"); end
    checks++; if (bus.result !== 4'h8) begin errors++; $display("[TB] FAIL ignore_result got %h want 8", bus.result); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_queue got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int  bc;
    bit  ok;
    bit  saw_done;
    @(negedge clk);
    bus.a = 4'd5; bus.b = 4'd3; bus.arit = 1'b1; bus.s = 2'b00; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 4'h0) begin errors++; $display("[TB] FAIL abort_result got %h want 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL abort_zero got %b want 1", bus.zero); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done got %b want 0", saw_done); end
    do_op(4'd7, 4'd1, 1'b1, 2'b00, 1'b0, bc, ok);
    checks++; if (bus.result !== 4'h8) begin errors++; $display("[TB] FAIL post_reset_result got %h want 8", bus.result); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
